rc_branch_serializer: RTL and testbench



---
 rtl/rc_branch_serializer.sv | 154 +++++++++++++++
 tb/tb_rc_branch_serializer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rc_branch_serializer.sv
// rc_branch_serializer
// Captures the three multicast branches produced by route compute and issues
// the live ones, one per handshake, to the switch allocator. rc_ready holds
// route compute off until every live branch of the current header is accepted.
module rc_branch_serializer #(
    parameter int DATASIZE = 30,
    parameter int DST_LSB  = 9,
    parameter int DST_MSB  = 24,
    parameter int CNT_W    = 8
) (
    input  logic                rc_clk,
    input  logic                rst_n,
    input  logic [DATASIZE-1:0] data_in1,
    input  logic [4:0]          direction_in1,
    input  logic [DATASIZE-1:0] data_in2,
    input  logic [4:0]          direction_in2,
    input  logic [DATASIZE-1:0] data_in3,
    input  logic [4:0]          direction_in3,
    output logic                rc_ready,
    output logic [DATASIZE-1:0] out_data,
    output logic [4:0]          out_direction,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                set_done,
    output logic [CNT_W-1:0]    issued_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        ISSUE   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [2:0]          pending;
    logic [2:0]          pending_next;
    logic [2:0]          live_in;
    logic [2:0]          grant;
    logic                fire;
    logic                last_fire;

    logic [DATASIZE-1:0] data_in_a [3];
    logic [4:0]          dir_in_a  [3];
    logic [DATASIZE-1:0] data_r    [3];
    logic [4:0]          dir_r     [3];

    // Gather the three input pairs into arrays so the branch logic can loop.
    always_comb begin
        data_in_a[0] = data_in1;
        data_in_a[1] = data_in2;
        data_in_a[2] = data_in3;
        dir_in_a[0]  = direction_in1;
        dir_in_a[1]  = direction_in2;
        dir_in_a[2]  = direction_in3;
    end

    // A branch is live only if it has both a direction and some destination bit.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            live_in[i] = (dir_in_a[i] != 5'd0) &&
                         (data_in_a[i][DST_MSB:DST_LSB] != '0);
        end
    end

    // Fixed priority: branch 1 first, then 2, then 3.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the if/case leaves it unassigned, which would infer a latch.
        grant = 3'b000;
        if (pending[0])      grant = 3'b001;
        else if (pending[1]) grant = 3'b010;
        else if (pending[2]) grant = 3'b100;
    end

    assign fire      = (state == ISSUE) && out_ready;
    assign last_fire = fire && ((pending & ~grant) == 3'b000);

    // Next-state and pending-mask update.
    always_comb begin
        state_next   = state;
        pending_next = pending;
        case (state)
            IDLE: begin
                // Route compute loads its outputs on this same edge.
                state_next = CAPTURE;
            end
            CAPTURE: begin
                pending_next = live_in;
                state_next   = (live_in != 3'b000) ? ISSUE : IDLE;
            end
            ISSUE: begin
                if (fire) begin
                    pending_next = pending & ~grant;
                    if (last_fire) state_next = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                pending_next = 3'b000;
            end
        endcase
    end

    // State, pending mask, branch capture, counter and done pulse.
    always_ff @(posedge rc_clk) begin
        if (!rst_n) begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state      <= IDLE;
            pending    <= 3'b000;
            issued_cnt <= '0;
            set_done   <= 1'b0;
            // NOTE: the branch store is three plain flop sets, not a RAM, so it
            // is cleared on reset to keep its contents deterministic.
            for (int i = 0; i < 3; i++) begin
                data_r[i] <= '0;
                dir_r[i]  <= 5'd0;
            end
        end else begin
            state    <= state_next;
            pending  <= pending_next;
            set_done <= last_fire;
            if (fire) issued_cnt <= issued_cnt + 1'b1;
            if (state == CAPTURE) begin
                for (int i = 0; i < 3; i++) begin
                    data_r[i] <= data_in_a[i];
                    dir_r[i]  <= dir_in_a[i];
                end
            end
        end
    end

    // Output mux: the granted branch while issuing, zeros otherwise. The
    // source registers and pending mask only change on a handshake, so the
    // presented branch holds steady under backpressure.
    always_comb begin
        out_data      = '0;
        out_direction = 5'd0;
        if (state == ISSUE) begin
            for (int i = 0; i < 3; i++) begin
                if (grant[i]) begin
                    out_data      = data_r[i];
                    out_direction = dir_r[i];
                end
            end
        end
    end

    assign out_valid = (state == ISSUE);
    // Held low while reset is asserted so route compute cannot advance.
    assign rc_ready  = (state == IDLE) && rst_n;

endmodule

// File: tb/tb_rc_branch_serializer.sv
// Self-checking bench for rc_branch_serializer: directed vector table,
// randomized sets against a queue-based model, counter wrap, reset mid-issue.
module tb_rc_branch_serializer;

    localparam int DATASIZE = 30;
    localparam int CNT_W    = 8;

    logic                rc_clk = 1'b0;
    logic                rst_n;
    logic [DATASIZE-1:0] data_in1, data_in2, data_in3;
    logic [4:0]          direction_in1, direction_in2, direction_in3;
    logic                rc_ready;
    logic [DATASIZE-1:0] out_data;
    logic [4:0]          out_direction;
    logic                out_valid;
    logic                out_ready;
    logic                set_done;
    logic [CNT_W-1:0]    issued_cnt;

    int                  total = 0;
    int                  bad   = 0;
    logic [CNT_W-1:0]    exp_cnt;

    always #5 rc_clk = ~rc_clk;

    rc_branch_serializer #(
        .DATASIZE(30), .DST_LSB(9), .DST_MSB(24), .CNT_W(8)
    ) dut (
        .rc_clk        (rc_clk),
        .rst_n         (rst_n),
        .data_in1      (data_in1),
        .direction_in1 (direction_in1),
        .data_in2      (data_in2),
        .direction_in2 (direction_in2),
        .data_in3      (data_in3),
        .direction_in3 (direction_in3),
        .rc_ready      (rc_ready),
        .out_data      (out_data),
        .out_direction (out_direction),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .set_done      (set_done),
        .issued_cnt    (issued_cnt)
    );

    typedef struct {
        logic [29:0] d1, d2, d3;
        logic [4:0]  r1, r2, r3;
        int          mode;      // 0: ready high, 1: random ready, 2: 4-cycle stall
        int          exp_n;
        logic [14:0] exp_dirs;  // accepted directions, first in the low 5 bits
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Live-branch rule: some direction bit and some destination bit [24:9].
    function automatic bit is_live(input logic [29:0] d, input logic [4:0] r);
        return (r != 5'd0) && (d[24:9] != 16'd0);
    endfunction

    task automatic scramble();
        logic [31:0] t;
        t = $urandom; data_in1 = t[29:0];
        t = $urandom; data_in2 = t[29:0];
        t = $urandom; data_in3 = t[29:0];
        t = $urandom;
        direction_in1 = t[4:0];
        direction_in2 = t[12:8];
        direction_in3 = t[20:16];
    endtask

    // Present one header, then drain it while comparing against the model queue.
    task automatic run_set(input logic [29:0] d1, input logic [29:0] d2, input logic [29:0] d3,
                           input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] r3,
                           input int mode, output int n_out, output logic [14:0] dirs);
        logic [29:0] qd[$];
        logic [4:0]  qr[$];
        int          waited;
        int          cyc;
        bit          any;
        n_out  = 0;
        dirs   = '0;
        waited = 0;
        while (rc_ready !== 1'b1 && waited < 20) begin
            @(negedge rc_clk);
            waited++;
        end
        if (waited >= 20) check("wait_ready", {63'd0, rc_ready}, 64'd1);
        data_in1 = d1; direction_in1 = r1;
        data_in2 = d2; direction_in2 = r2;
        data_in3 = d3; direction_in3 = r3;
        if (is_live(d1, r1)) begin qd.push_back(d1); qr.push_back(r1); end
        if (is_live(d2, r2)) begin qd.push_back(d2); qr.push_back(r2); end
        if (is_live(d3, r3)) begin qd.push_back(d3); qr.push_back(r3); end
        any = (qd.size() != 0);
        @(negedge rc_clk);
        check("capture_ready", {63'd0, rc_ready}, 64'd0);
        check("capture_valid", {63'd0, out_valid}, 64'd0);
        @(posedge rc_clk);
        #1 scramble();
        @(negedge rc_clk);
        cyc = 0;
        while (qd.size() != 0 && cyc < 60) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (cyc >= 4);
            endcase
            check("issue_valid", {63'd0, out_valid}, 64'd1);
            check("issue_data", 64'(out_data), 64'(qd[0]));
            check("issue_dir", 64'(out_direction), 64'(qr[0]));
            check("issue_done", {63'd0, set_done}, 64'd0);
            if (out_ready) begin
                dirs = dirs | (15'(qr[0]) << (5 * n_out));
                n_out++;
                void'(qd.pop_front());
                void'(qr.pop_front());
                exp_cnt = exp_cnt + 1'b1;
            end
            @(posedge rc_clk);
            #1 scramble();
            @(negedge rc_clk);
            cyc++;
        end
        if (qd.size() != 0) check("issue_timeout", 64'(qd.size()), 64'd0);
        out_ready = 1'b0;
        check("done_pulse", {63'd0, set_done}, {63'd0, any});
        check("idle_valid", {63'd0, out_valid}, 64'd0);
        check("idle_data", 64'(out_data), 64'd0);
        check("idle_dir", 64'(out_direction), 64'd0);
        check("count", 64'(issued_cnt), 64'(exp_cnt));
        check("ready_back", {63'd0, rc_ready}, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[6];
        int          n;
        logic [14:0] dirs;
        logic [31:0] t;
        logic [29:0] rd[3];
        logic [4:0]  rr[3];

        vecs[0] = '{ {5'h01,16'h00F0,9'h011}, {5'h02,16'h8000,9'h022}, {5'h03,16'h0001,9'h033},
                     5'b00100, 5'b00001, 5'b00010, 0, 3, 15'b00010_00001_00100 };
        vecs[1] = '{ {5'h04,16'h1234,9'h044}, {5'h1F,16'h0000,9'h1FF}, {5'h05,16'hFFFF,9'h055},
                     5'b00001, 5'b01000, 5'b00000, 0, 1, 15'b00000_00000_00001 };
        vecs[2] = '{ {5'h06,16'h0101,9'h066}, {5'h07,16'h0202,9'h077}, {5'h08,16'h0303,9'h088},
                     5'b00000, 5'b00000, 5'b00000, 0, 0, 15'd0 };
        vecs[3] = '{ {5'h09,16'hA5A5,9'h099}, {5'h0A,16'h5A5A,9'h0AA}, {5'h0B,16'h0F0F,9'h0BB},
                     5'b00100, 5'b00001, 5'b00010, 2, 3, 15'b00010_00001_00100 };
        vecs[4] = '{ {5'h0C,16'h0010,9'h0CC}, {5'h0D,16'h0000,9'h0DD}, {5'h0E,16'h4000,9'h0EE},
                     5'b00000, 5'b10000, 5'b10110, 0, 1, 15'b00000_00000_10110 };
        vecs[5] = '{ {5'h10,16'h0000,9'h1FF}, {5'h11,16'h0300,9'h011}, {5'h12,16'h0007,9'h012},
                     5'b00001, 5'b01000, 5'b11111, 1, 2, 15'b00000_11111_01000 };

        // Reset with random inputs for two edges.
        rst_n     = 1'b0;
        out_ready = 1'b0;
        exp_cnt   = '0;
        scramble();
        @(posedge rc_clk);
        @(posedge rc_clk);
        @(negedge rc_clk);
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_cnt", 64'(issued_cnt), 64'd0);
        check("rst_done", {63'd0, set_done}, 64'd0);
        check("rst_ready_low", {63'd0, rc_ready}, 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        rst_n = 1'b1;
        #1 check("rst_ready_high", {63'd0, rc_ready}, 64'd1);

        // Directed vectors.
        for (int i = 0; i < 6; i++) begin
            run_set(vecs[i].d1, vecs[i].d2, vecs[i].d3,
                    vecs[i].r1, vecs[i].r2, vecs[i].r3, vecs[i].mode, n, dirs);
            check($sformatf("vec%0d_n", i), 64'(n), 64'(vecs[i].exp_n));
            check($sformatf("vec%0d_dirs", i), 64'(dirs), 64'(vecs[i].exp_dirs));
        end

        // Randomized sets with random backpressure.
        for (int s = 0; s < 30; s++) begin
            for (int b = 0; b < 3; b++) begin
                t = $urandom;
                rd[b] = t[29:0];
                if ($urandom_range(0, 3) == 0) rd[b][24:9] = 16'd0;
                t = $urandom;
                rr[b] = ($urandom_range(0, 3) == 0) ? 5'd0 : t[4:0];
            end
            run_set(rd[0], rd[1], rd[2], rr[0], rr[1], rr[2], 1, n, dirs);
        end

        // Drive the counter to 255 with single-branch sets, then wrap it.
        while (exp_cnt != 8'hFF) begin
            run_set({5'h01,16'h0001,9'h001}, 30'd0, 30'd0, 5'b00001, 5'd0, 5'd0, 0, n, dirs);
        end
        check("pre_wrap", 64'(issued_cnt), 64'd255);
        run_set({5'h02,16'h0002,9'h002}, 30'd0, 30'd0, 5'b00010, 5'd0, 5'd0, 0, n, dirs);
        check("wrap", 64'(issued_cnt), 64'd0);

        // Reset while issuing with two branches pending.
        data_in1 = {5'h01,16'h0100,9'h001}; direction_in1 = 5'b00001;
        data_in2 = {5'h02,16'h0200,9'h002}; direction_in2 = 5'b00010;
        data_in3 = {5'h03,16'h0300,9'h003}; direction_in3 = 5'b00000;
        @(posedge rc_clk);
        @(posedge rc_clk);
        @(negedge rc_clk);
        out_ready = 1'b0;
        check("mid_valid", {63'd0, out_valid}, 64'd1);
        check("mid_dir", 64'(out_direction), 64'd1);
        rst_n = 1'b0;
        @(negedge rc_clk);
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_done", {63'd0, set_done}, 64'd0);
        check("mid_rst_cnt", 64'(issued_cnt), 64'd0);
        check("mid_rst_ready", {63'd0, rc_ready}, 64'd0);
        rst_n   = 1'b1;
        exp_cnt = '0;
        #1 check("mid_rst_idle", {63'd0, rc_ready}, 64'd1);
        run_set(vecs[0].d1, vecs[0].d2, vecs[0].d3,
                vecs[0].r1, vecs[0].r2, vecs[0].r3, 0, n, dirs);
        check("after_rst_n", 64'(n), 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
